// File: rtl/ics_tap_if.sv
`default_nettype none
// ============================================================================
// Module      : ics_tap_if
// Description : JTAG serial pin bundle (TMS/TDI in, TDO out) for ics_tap.
// Revision    : 1.0 - initial release
// ============================================================================
interface ics_tap_if;
    logic TMS;
    logic TDI;
    logic TDO;

    modport master (output TMS, output TDI, input TDO);
    modport slave  (input TMS, input TDI, output TDO);
endinterface
`default_nettype wire

// File: rtl/ics_tap.sv
`default_nettype none
// ============================================================================
// Module      : ics_tap
// Description : IEEE 1149.1-style TAP with IDCODE, BYPASS and 8-bit USER DRs.
// Revision    : 1.0 - initial release
// ============================================================================
module ics_tap #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_563D
) (
    input  wire logic TCK,
    input  wire logic TRST,
    ics_tap_if.slave  jtag
);

    localparam logic [IR_WIDTH-1:0] c_IR_IDCODE  = IR_WIDTH'(4'b0001);
    localparam logic [IR_WIDTH-1:0] c_IR_USER    = IR_WIDTH'(4'b1000);
    localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = IR_WIDTH'(4'b0101);

    typedef enum logic [3:0] {
        S_TLR    = 4'd0,
        S_RTI    = 4'd1,
        S_SEL_DR = 4'd2,
        S_CAP_DR = 4'd3,
        S_SH_DR  = 4'd4,
        S_EX1_DR = 4'd5,
        S_PA_DR  = 4'd6,
        S_EX2_DR = 4'd7,
        S_UPD_DR = 4'd8,
        S_SEL_IR = 4'd9,
        S_CAP_IR = 4'd10,
        S_SH_IR  = 4'd11,
        S_EX1_IR = 4'd12,
        S_PA_IR  = 4'd13,
        S_EX2_IR = 4'd14,
        S_UPD_IR = 4'd15
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   r_sh_ir;
    logic [31:0]           r_sh_id;
    logic [7:0]            r_sh_user;
    logic [7:0]            r_user;
    logic                  r_sh_bp;
    logic                  r_tdo;
    logic                  w_tdo_next;
    logic                  w_sel_idcode;
    logic                  w_sel_user;

    assign w_sel_idcode = (r_ir == c_IR_IDCODE);
    assign w_sel_user   = (r_ir == c_IR_USER);
    assign jtag.TDO     = r_tdo;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_TLR:    w_state_next = jtag.TMS ? S_TLR    : S_RTI;
            S_RTI:    w_state_next = jtag.TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_state_next = jtag.TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_state_next = jtag.TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_state_next = jtag.TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_state_next = jtag.TMS ? S_UPD_DR : S_PA_DR;
            S_PA_DR:  w_state_next = jtag.TMS ? S_EX2_DR : S_PA_DR;
            S_EX2_DR: w_state_next = jtag.TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_state_next = jtag.TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_state_next = jtag.TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_state_next = jtag.TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_state_next = jtag.TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_state_next = jtag.TMS ? S_UPD_IR : S_PA_IR;
            S_PA_IR:  w_state_next = jtag.TMS ? S_EX2_IR : S_PA_IR;
            S_EX2_IR: w_state_next = jtag.TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_state_next = jtag.TMS ? S_SEL_DR : S_RTI;
            default:  w_state_next = S_TLR;
        endcase
    end

    // Capture and shift happen on the rising edge; only the selected DR moves.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_sh_ir   <= '0;
            r_sh_id   <= '0;
            r_sh_user <= '0;
            r_sh_bp   <= 1'b0;
        end else begin
            case (r_state)
                S_CAP_IR: r_sh_ir <= c_IR_CAPTURE;
                S_SH_IR:  r_sh_ir <= {jtag.TDI, r_sh_ir[IR_WIDTH-1:1]};
                S_CAP_DR: begin
                    if (w_sel_idcode) begin
                        r_sh_id <= IDCODE_VALUE;
                    end else if (w_sel_user) begin
                        r_sh_user <= r_user;
                    end else begin
                        r_sh_bp <= 1'b0;
                    end
                end
                S_SH_DR: begin
                    if (w_sel_idcode) begin
                        r_sh_id <= {jtag.TDI, r_sh_id[31:1]};
                    end else if (w_sel_user) begin
                        r_sh_user <= {jtag.TDI, r_sh_user[7:1]};
                    end else begin
                        r_sh_bp <= jtag.TDI;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tdo_next = 1'b0;
        if (r_state == S_SH_IR) begin
            w_tdo_next = r_sh_ir[0];
        end else if (r_state == S_SH_DR) begin
            if (w_sel_idcode) begin
                w_tdo_next = r_sh_id[0];
            end else if (w_sel_user) begin
                w_tdo_next = r_sh_user[0];
            end else begin
                w_tdo_next = r_sh_bp;
            end
        end
    end

    // Falling edge: TDO launch, update of IR/USER, and IR reload while in TLR.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_ir   <= c_IR_IDCODE;
            r_user <= 8'h00;
            r_tdo  <= 1'b0;
        end else begin
            r_tdo <= w_tdo_next;
            case (r_state)
                S_TLR:    r_ir <= c_IR_IDCODE;
                S_UPD_IR: r_ir <= r_sh_ir;
                S_UPD_DR: begin
                    if (w_sel_user) begin
                        r_user <= r_sh_user;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ics_tap.sv
`default_nettype none
// ============================================================================
// Module      : tb_ics_tap
// Description : Self-checking bench for ics_tap against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ics_tap;

    localparam logic [31:0] IDV = 32'h1000_563D;

    localparam int M_TLR = 0,  M_RTI = 1,  M_SDR = 2,  M_CDR = 3;
    localparam int M_SHDR = 4, M_E1DR = 5, M_PDR = 6,  M_E2DR = 7;
    localparam int M_UDR = 8,  M_SIR = 9,  M_CIR = 10, M_SHIR = 11;
    localparam int M_E1IR = 12, M_PIR = 13, M_E2IR = 14, M_UIR = 15;

    // Successor tables taken straight from the TAP state diagram.
    int nxt0 [16] = '{M_RTI, M_RTI, M_CDR, M_SHDR, M_SHDR, M_PDR, M_PDR, M_SHDR,
                      M_RTI, M_CIR, M_SHIR, M_SHIR, M_PIR, M_PIR, M_SHIR, M_RTI};
    int nxt1 [16] = '{M_TLR, M_SDR, M_SIR, M_E1DR, M_E1DR, M_UDR, M_E2DR, M_UDR,
                      M_SDR, M_TLR, M_E1IR, M_E1IR, M_UIR, M_E2IR, M_UIR, M_SDR};

    logic TCK  = 1'b0;
    logic TRST = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   mstate = M_TLR;
    logic [3:0] m_ir   = 4'b0001;
    logic [7:0] m_user = 8'h00;

    ics_tap_if jtag ();

    ics_tap #(
        .IR_WIDTH     (4),
        .IDCODE_VALUE (IDV)
    ) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .jtag (jtag)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at falling edge + 1; returns the TDO the master sees at the next rising edge.
    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        tdo      = jtag.TDO;
        jtag.TMS = tms;
        jtag.TDI = tdi;
        @(posedge TCK);
        mstate = tms ? nxt1[mstate] : nxt0[mstate];
        if (mstate == M_TLR) m_ir = 4'b0001;
        @(negedge TCK);
        #1;
    endtask

    function automatic logic [31:0] dr_expect(input int n, input logic [31:0] din);
        logic [31:0] r;
        r = '0;
        case (m_ir)
            4'b0001: r = IDV;
            4'b1000: r = {24'h0, m_user};
            default: for (int i = 1; i < n; i++) r[i] = din[i-1];
        endcase
        return r;
    endfunction

    // IR scan from RTI back to RTI; cap holds the bits shifted out LSB-first.
    task automatic ir_scan(input logic [3:0] v, output logic [3:0] cap);
        logic t;
        tick(1'b1, 1'b0, t); tick(1'b1, 1'b0, t); tick(1'b0, 1'b0, t); tick(1'b0, 1'b0, t);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, v[i], t);
            cap[i] = t;
        end
        tick(1'b1, 1'b0, t); tick(1'b0, 1'b0, t);
        m_ir = v;
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic t;
        dout = '0;
        tick(1'b1, 1'b0, t); tick(1'b0, 1'b0, t); tick(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], t);
            dout[i] = t;
        end
        tick(1'b1, 1'b0, t); tick(1'b0, 1'b0, t);
        if (m_ir == 4'b1000) m_user = din[7:0];
    endtask

    initial begin
        logic        t;
        logic [3:0]  cap;
        logic [31:0] dout;
        logic [31:0] exp;
        logic [7:0]  v;
        int          prev;

        jtag.TMS = 1'b1;
        jtag.TDI = 1'b0;
        #23;
        check("reset_tdo",  {31'h0, jtag.TDO}, 32'h0);
        check("reset_ir",   {28'h0, dut.r_ir}, 32'h1);
        check("reset_user", {24'h0, dut.r_user}, 32'h0);
        @(negedge TCK); #1;
        TRST = 1'b1;

        tick(1'b0, 1'b0, t);
        check("rti_tdo", {31'h0, jtag.TDO}, 32'h0);

        exp = dr_expect(32, 32'h0);
        dr_scan(32, 32'h0, dout);
        check("idcode_read", dout, exp);
        check("idcode_const", dout, IDV);

        ir_scan(4'b1111, cap);
        check("ir_capture", {28'h0, cap}, 32'h5);

        exp = dr_expect(5, 32'b10110);
        dr_scan(5, 32'b10110, dout);
        check("bypass_model", dout, exp);
        check("bypass_const", dout, 32'b01100);

        // Five TMS=1 edges from SH_DR must land in TLR, which restores IDCODE.
        tick(1'b1, 1'b0, t); tick(1'b0, 1'b0, t); tick(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t);
        tick(1'b0, 1'b0, t);
        dr_scan(32, 32'hFFFF_FFFF, dout);
        check("tlr_from_shdr", dout, IDV);

        ir_scan(4'b1000, cap);
        check("ir_capture_user", {28'h0, cap}, 32'h5);
        exp = dr_expect(8, 32'hA5);
        dr_scan(8, 32'hA5, dout);
        check("user_initial", dout, exp);
        exp = dr_expect(8, 32'h3C);
        dr_scan(8, 32'h3C, dout);
        check("user_a5", dout, exp);
        check("user_a5_const", dout, 32'hA5);
        for (int k = 0; k < 6; k++) begin
            v   = 8'($urandom);
            exp = dr_expect(8, {24'h0, v});
            dr_scan(8, {24'h0, v}, dout);
            check("user_loop", dout, exp);
        end

        // Random TMS walk: TDO must be 0 whenever the TAP is outside a shift state.
        for (int k = 0; k < 60; k++) begin
            prev = mstate;
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
            if (prev != M_SHDR && prev != M_SHIR) check("walk_tdo_idle", {31'h0, t}, 32'h0);
        end
        for (int k = 0; k < 5; k++) tick(1'b1, 1'($urandom_range(0, 1)), t);
        tick(1'b0, 1'b0, t);
        dr_scan(32, 32'h0, dout);
        check("walk_then_idcode", dout, IDV);

        // Abort a USER scan with TRST: nothing partial may reach USER or IR.
        ir_scan(4'b1000, cap);
        dr_scan(8, 32'h5A, dout);
        tick(1'b1, 1'b0, t); tick(1'b0, 1'b0, t); tick(1'b0, 1'b0, t);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, t);
        #2;
        TRST = 1'b0;
        #1;
        mstate = M_TLR; m_ir = 4'b0001; m_user = 8'h00;
        check("trst_tdo",  {31'h0, jtag.TDO}, 32'h0);
        check("trst_ir",   {28'h0, dut.r_ir}, 32'h1);
        check("trst_user", {24'h0, dut.r_user}, 32'h0);
        @(negedge TCK); #1;
        TRST = 1'b1;
        tick(1'b0, 1'b0, t);
        dr_scan(32, 32'h0, dout);
        check("trst_idcode", dout, IDV);
        ir_scan(4'b1000, cap);
        exp = dr_expect(8, 32'h11);
        dr_scan(8, 32'h11, dout);
        check("trst_user_scan", dout, exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ics_tap.md
# ics_tap

JTAG (IEEE 1149.1-style) test access port for the ICS test-interface block. A 16-state TAP controller clocked by TCK decodes TMS and routes TDI/TDO through a 4-bit instruction register and one of three data registers: IDCODE, BYPASS or an 8-bit USER scratch register. It sits at the chip's JTAG pins and gives board-level test access.

## Interface
Parameters:
- IR_WIDTH, 4: instruction register width.
- IDCODE_VALUE, 32'h1000_563D: device ID; bit 0 must be 1.

Ports:
- TCK  input  1  test clock; the only clock.
- TRST  input  1  test reset; asynchronous, active-low.
- TMS  input  1  mode select, sampled on TCK rising edge.
- TDI  input  1  serial data in, sampled on TCK rising edge.
- TDO  output  1  serial data out, changes on TCK falling edge.

## Operation
- **Reset.** TRST=0 immediately forces the following, regardless of TCK:
  - state TEST_LOGIC_RESET;
  - IR = IDCODE (4'b0001);
  - USER register = 8'h00;
  - TDO = 0.
- **State machine** (TMS=0 / TMS=1 successor for each state):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PA_DR / UPD_DR
  - PA_DR: PA_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - The IR branch (CAP_IR … UPD_IR) mirrors the DR branch.
- **Entering TLR** also reloads IR with IDCODE.
- **Instruction decode:**
  - 4'b0001: IDCODE, 32-bit register.
  - 4'b1000: USER, 8-bit register.
  - 4'b1111 and all other codes: BYPASS, 1-bit register.
- **Capture** (rising edge while in CAP_xx):
  - IR shift register loads 4'b0101.
  - IDCODE shift register loads IDCODE_VALUE.
  - BYPASS loads 0.
  - USER shift register loads the current USER register value.
- **Shift** (rising edge while in SH_xx): the selected shift register shifts right; TDI enters the MSB.
- **Update** (falling edge while in UPD_xx):
  - UPD_IR: IR takes the IR shift register.
  - UPD_DR with USER selected: USER register takes the USER shift register.
  - IDCODE and BYPASS have no update effect.
  - IR and USER change only on update.
- **TDO** (falling edge of TCK):
  - In SH_IR or SH_DR: LSB of the active shift register.
  - In all other states: 0.

## Timing
- State changes on the TCK rising edge using the sampled TMS.
- Five consecutive TMS=1 rising edges reach TLR from any state.
- TDO lags its shift register by half a cycle, so the TAP master samples it on the next rising edge.
- Capture/shift framing: the first bit out in a shift sequence is the captured LSB, visible after the falling edge following entry to SH_xx.
- An N-bit register needs N rising edges in SH_xx; the last one is taken with TMS=1, exiting to EX1_xx.
- BYPASS gives exactly 1 TCK of TDI→TDO delay; the first bit out is 0.
- Pause states hold shift register contents unchanged.
- TRST asserted mid-shift or mid-update aborts the operation: no partial update of IR or USER.
- Releasing TRST is synchronous to nothing; the first active rising edge after release evaluates from TLR.

## Test plan
- Reset: pulse TRST low → state TLR, TDO=0, IR=4'b0001. Then TMS=0 for 1 edge → RTI.
- TMS walk: from SH_DR, apply 5 edges with TMS=1 → TLR. Sequence 0,1,0,0 from TLR → RTI, SEL_DR, CAP_DR, SH_DR.
- IDCODE read: after reset, navigate to SH_DR and shift 32 bits with TDI=0 → TDO stream LSB-first equals 32'h1000_563D.
- IR capture/load: in SH_IR shift in 4'b1111 → first 4 TDO bits are 1,0,1,0. After UPD_IR, a DR shift of 0,1,1,0,1 on TDI → TDO 0,0,1,1,0 (one-cycle delay).
- USER loopback: load IR 4'b1000. DR-shift 8'hA5 and pass UPD_DR. A second DR scan returns 8'hA5 LSB-first while shifting in 8'h3C. A third scan returns 8'h3C.
- Async reset mid-operation: assert TRST during SH_DR of a USER scan → immediate TLR, TDO=0, IR=IDCODE, USER=8'h00 with no update applied.
